// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - register-bank writeback arbiter with busy scoreboard
module regfile_wb_arbiter #(
  parameter int WORD_SIZE    = 32,
  parameter int BANK_SIZE    = 32,
  parameter int STARVE_LIMIT = 3
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 a_valid,
  input  logic [4:0]           a_addr,
  input  logic [WORD_SIZE-1:0] a_data,
  output logic                 a_ready,
  input  logic                 m_valid,
  input  logic [4:0]           m_addr,
  input  logic [WORD_SIZE-1:0] m_data,
  output logic                 m_ready,
  input  logic                 issue_valid,
  input  logic [4:0]           issue_rd,
  input  logic [4:0]           issue_rs1,
  input  logic [4:0]           issue_rs2,
  output logic                 issue_stall,
  output logic                 wb_we,
  output logic [4:0]           wb_addr,
  output logic [WORD_SIZE-1:0] wb_data
);

  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  logic [3:0]           starve_q, starve_d;
  logic                 wb_we_q, wb_we_d;
  logic [4:0]           wb_addr_q, wb_addr_d;
  logic [WORD_SIZE-1:0] wb_data_q, wb_data_d;
  logic [BANK_SIZE-1:0] busy_q, busy_d;
  logic                 grant_a, grant_m;
  logic [4:0]           sel_addr;
  logic [WORD_SIZE-1:0] sel_data;
  logic                 hz_rs1, hz_rs2, hz_rd;

  // A source is a hazard only if busy and not being forwarded from the in-flight write
  function automatic logic hazard(input logic [4:0] r, input logic [BANK_SIZE-1:0] busy,
                                  input logic we, input logic [4:0] wa);
    return (r != 5'd0) && busy[r] && !(we && (wa == r));
  endfunction

  // Grant: M by default, A once it has been denied STARVE_LIMIT cycles in a row
  always_comb begin
    grant_a  = a_valid && (!m_valid || (starve_q == STARVE_MAX));
    grant_m  = m_valid && !grant_a;
    sel_addr = grant_a ? a_addr : m_addr;
    sel_data = grant_a ? a_data : m_data;
  end

  assign a_ready = grant_a;
  assign m_ready = grant_m;

  // Starvation counter: counts consecutive denials of A, saturating
  always_comb begin
    starve_d = 4'd0;
    if (a_valid && !grant_a)
      starve_d = (starve_q == STARVE_MAX) ? starve_q : starve_q + 4'd1;
  end

  // Write port next state: register the granted beat; address-0 beats are discarded
  always_comb begin
    wb_we_d   = 1'b0;
    wb_addr_d = wb_addr_q;
    wb_data_d = wb_data_q;
    if ((grant_a || grant_m) && (sel_addr != 5'd0)) begin
      wb_we_d   = 1'b1;
      wb_addr_d = sel_addr;
      wb_data_d = sel_data;
    end
  end

  // Hazard detection against the scoreboard
  always_comb begin
    hz_rs1      = hazard(issue_rs1, busy_q, wb_we_q, wb_addr_q);
    hz_rs2      = hazard(issue_rs2, busy_q, wb_we_q, wb_addr_q);
    hz_rd       = hazard(issue_rd,  busy_q, wb_we_q, wb_addr_q);
    issue_stall = issue_valid && (hz_rs1 || hz_rs2 || hz_rd);
  end

  // Scoreboard: commit clears first, then a new issue sets (newer producer wins)
  always_comb begin
    busy_d = busy_q;
    if (wb_we_q)
      busy_d[wb_addr_q] = 1'b0;
    if (issue_valid && !issue_stall && (issue_rd != 5'd0))
      busy_d[issue_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  // State registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      starve_q  <= 4'd0;
      wb_we_q   <= 1'b0;
      wb_addr_q <= 5'd0;
      wb_data_q <= '0;
      busy_q    <= '0;
    end else begin
      starve_q  <= starve_d;
      wb_we_q   <= wb_we_d;
      wb_addr_q <= wb_addr_d;
      wb_data_q <= wb_data_d;
      busy_q    <= busy_d;
    end
  end

  assign wb_we   = wb_we_q;
  assign wb_addr = wb_addr_q;
  assign wb_data = wb_data_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - directed self-checking bench for regfile_wb_arbiter
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        a_valid, m_valid, issue_valid;
  logic [4:0]  a_addr, m_addr, issue_rd, issue_rs1, issue_rs2;
  logic [31:0] a_data, m_data, wb_data;
  logic        a_ready, m_ready, issue_stall, wb_we;
  logic [4:0]  wb_addr;

  int vectors = 0;
  int miscompares = 0;

  regfile_wb_arbiter #(.WORD_SIZE(32), .BANK_SIZE(32), .STARVE_LIMIT(3)) dut (
    .clk(clk), .rstn(rstn),
    .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready),
    .m_valid(m_valid), .m_addr(m_addr), .m_data(m_data), .m_ready(m_ready),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_rs1(issue_rs1),
    .issue_rs2(issue_rs2), .issue_stall(issue_stall),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data)
  );

  always #5 clk = ~clk;

  task automatic idle();
    a_valid = 0; a_addr = 0; a_data = 0;
    m_valid = 0; m_addr = 0; m_data = 0;
    issue_valid = 0; issue_rd = 0; issue_rs1 = 0; issue_rs2 = 0;
  endtask

  task automatic test_reset();
    idle();
    rstn = 0;
    repeat (2) @(posedge clk);
    #1;
    vectors++; if (wb_we !== 1'b0) begin miscompares++; $display("FAIL reset_wb_we: got %b want 0", wb_we); end
    vectors++; if (wb_addr !== 5'd0) begin miscompares++; $display("FAIL reset_wb_addr: got %h want 0", wb_addr); end
    vectors++; if (wb_data !== 32'd0) begin miscompares++; $display("FAIL reset_wb_data: got %h want 0", wb_data); end
    vectors++; if ({a_ready, m_ready, issue_stall} !== 3'b000) begin miscompares++; $display("FAIL reset_comb: got %b want 000", {a_ready, m_ready, issue_stall}); end
    @(negedge clk);
    rstn = 1;
  endtask

  task automatic test_single_a();
    @(negedge clk);
    a_valid = 1; a_addr = 5; a_data = 32'hDEAD;
    #1;
    vectors++; if (a_ready !== 1'b1) begin miscompares++; $display("FAIL single_a_ready: got %b want 1", a_ready); end
    vectors++; if (m_ready !== 1'b0) begin miscompares++; $display("FAIL single_m_ready: got %b want 0", m_ready); end
    @(posedge clk); #1;
    vectors++; if ({wb_we, wb_addr, wb_data} !== {1'b1, 5'd5, 32'hDEAD}) begin miscompares++; $display("FAIL single_wb: got we=%b addr=%0d data=%h want we=1 addr=5 data=dead", wb_we, wb_addr, wb_data); end
    @(negedge clk);
    idle();
    @(posedge clk); #1;
    vectors++; if ({wb_we, wb_addr, wb_data} !== {1'b0, 5'd5, 32'hDEAD}) begin miscompares++; $display("FAIL single_hold: got we=%b addr=%0d data=%h want we=0 addr=5 data=dead", wb_we, wb_addr, wb_data); end
  endtask

  task automatic test_starvation();
    logic exp_a;
    @(negedge clk);
    a_valid = 1; a_addr = 3; a_data = 32'hA3;
    m_valid = 1; m_addr = 4; m_data = 32'hB4;
    for (int i = 0; i < 8; i++) begin
      exp_a = (i % 4) == 3;
      #1;
      vectors++; if ({a_ready, m_ready} !== {exp_a, ~exp_a}) begin miscompares++; $display("FAIL starve_grant[%0d]: got a=%b m=%b want a=%b m=%b", i, a_ready, m_ready, exp_a, ~exp_a); end
      @(posedge clk); #1;
      vectors++; if ({wb_we, wb_addr} !== {1'b1, exp_a ? 5'd3 : 5'd4}) begin miscompares++; $display("FAIL starve_wb[%0d]: got we=%b addr=%0d want addr=%0d", i, wb_we, wb_addr, exp_a ? 3 : 4); end
      @(negedge clk);
    end
    idle();
    @(posedge clk);
  endtask

  task automatic test_addr0();
    @(negedge clk);
    a_valid = 1; a_addr = 0; a_data = 32'h1234;
    #1;
    vectors++; if (a_ready !== 1'b1) begin miscompares++; $display("FAIL addr0_ready: got %b want 1", a_ready); end
    @(posedge clk); #1;
    vectors++; if (wb_we !== 1'b0) begin miscompares++; $display("FAIL addr0_we: got %b want 0", wb_we); end
    @(negedge clk);
    idle();
    issue_valid = 1; issue_rs1 = 0; issue_rs2 = 5;
    #1;
    vectors++; if (issue_stall !== 1'b0) begin miscompares++; $display("FAIL addr0_busy: got stall=%b want 0", issue_stall); end
    @(negedge clk);
    idle();
  endtask

  task automatic test_raw();
    @(negedge clk);
    issue_valid = 1; issue_rd = 7;
    #1;
    vectors++; if (issue_stall !== 1'b0) begin miscompares++; $display("FAIL raw_issue_rd: got %b want 0", issue_stall); end
    @(negedge clk);
    issue_rd = 0; issue_rs1 = 7;
    for (int i = 0; i < 2; i++) begin
      #1;
      vectors++; if (issue_stall !== 1'b1) begin miscompares++; $display("FAIL raw_stall[%0d]: got %b want 1", i, issue_stall); end
      @(negedge clk);
    end
    a_valid = 1; a_addr = 7; a_data = 32'h77;
    #1;
    vectors++; if ({a_ready, issue_stall} !== 2'b11) begin miscompares++; $display("FAIL raw_pending: got ready=%b stall=%b want 1 1", a_ready, issue_stall); end
    @(posedge clk); #1;
    vectors++; if ({wb_we, wb_addr, issue_stall} !== {1'b1, 5'd7, 1'b0}) begin miscompares++; $display("FAIL raw_forward: got we=%b addr=%0d stall=%b want 1 7 0", wb_we, wb_addr, issue_stall); end
    @(negedge clk);
    a_valid = 0;
    @(posedge clk); #1;
    vectors++; if ({wb_we, issue_stall} !== 2'b00) begin miscompares++; $display("FAIL raw_cleared: got we=%b stall=%b want 0 0", wb_we, issue_stall); end
    @(negedge clk);
    idle();
  endtask

  task automatic test_set_wins();
    @(negedge clk);
    issue_valid = 1; issue_rd = 9;
    @(negedge clk);
    issue_valid = 0; issue_rd = 0;
    a_valid = 1; a_addr = 9; a_data = 32'h99;
    @(negedge clk);
    a_valid = 0;
    issue_valid = 1; issue_rd = 9;
    #1;
    vectors++; if ({wb_we, wb_addr, issue_stall} !== {1'b1, 5'd9, 1'b0}) begin miscompares++; $display("FAIL setwins_issue: got we=%b addr=%0d stall=%b want 1 9 0", wb_we, wb_addr, issue_stall); end
    @(negedge clk);
    issue_rd = 0; issue_rs2 = 9;
    #1;
    vectors++; if (issue_stall !== 1'b1) begin miscompares++; $display("FAIL setwins_rs2: got %b want 1", issue_stall); end
    @(negedge clk);
    idle();
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    issue_valid = 1; issue_rd = 2;
    @(negedge clk);
    issue_rd = 3;
    @(negedge clk);
    issue_rd = 3; issue_rs1 = 0;
    #1;
    vectors++; if (issue_stall !== 1'b1) begin miscompares++; $display("FAIL waw_stall: got %b want 1", issue_stall); end
    issue_valid = 0; issue_rd = 0;
    m_valid = 1; m_addr = 2; m_data = 32'h22;
    @(posedge clk); #1;
    vectors++; if ({wb_we, wb_addr} !== {1'b1, 5'd2}) begin miscompares++; $display("FAIL mid_pre: got we=%b addr=%0d want 1 2", wb_we, wb_addr); end
    rstn = 0;
    #1;
    vectors++; if ({wb_we, wb_addr, wb_data} !== {1'b0, 5'd0, 32'd0}) begin miscompares++; $display("FAIL mid_async: got we=%b addr=%0d data=%h want 0 0 0", wb_we, wb_addr, wb_data); end
    @(negedge clk);
    idle();
    rstn = 1;
    issue_valid = 1; issue_rs1 = 2;
    #1;
    vectors++; if (issue_stall !== 1'b0) begin miscompares++; $display("FAIL mid_rs1_2: got %b want 0", issue_stall); end
    issue_rs1 = 3;
    #1;
    vectors++; if (issue_stall !== 1'b0) begin miscompares++; $display("FAIL mid_rs1_3: got %b want 0", issue_stall); end
    @(negedge clk);
    idle();
  endtask

  initial begin
    test_reset();
    test_single_a();
    test_starvation();
    test_addr0();
    test_raw();
    test_set_wins();
    test_reset_mid();
    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
